// File: rtl/shared_reg_pkg.sv
// Shared register arbiter: common types and default sizing.
package shared_reg_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef logic [$clog2(N_DEF)-1:0] owner_t;

endpackage

// File: rtl/shared_reg_if.sv
// Container for the shared packed register so consumers can bind to one handle.
interface shared_reg_if #(
  parameter int W = 8
);
  logic [W-1:0] x;
endinterface

// File: rtl/rr_pick.sv
// Circular first-set search: lowest index at or after ptr_i among req_i & ~excl_i.
module rr_pick #(
  parameter int N  = 4,
  parameter int OW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [OW-1:0] ptr_i,
  input  logic [N-1:0]  excl_i,
  output logic          found_o,
  output logic [OW-1:0] idx_o
);

  logic [N-1:0]  cand;
  logic [OW-1:0] k;

  assign cand = req_i & ~excl_i;

  // Walk N positions starting at ptr_i; the first candidate wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    k       = '0;
    for (int i = 0; i < N; i++) begin
      k = OW'((int'(ptr_i) + i) % N);
      if (!found_o && cand[k]) begin
        found_o = 1'b1;
        idx_o   = k;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin owner of one shared W-bit register; the grantee writes masked bits.
//
//   state | meaning
//   IDLE  | no grant held, waiting for any request
//   GRANT | one requester owns the register; its write commits while it requests
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N-1:0]         i_req,
  input  logic [N-1:0]         i_lock,
  input  logic [N*W-1:0]       i_wmask,
  input  logic [N*W-1:0]       i_wdata,
  output logic [N-1:0]         o_gnt,
  output logic [$clog2(N)-1:0] o_owner,
  output logic                 o_busy,
  output logic [W-1:0]         o_q
);

  localparam int OW = $clog2(N);

  state_e        state_q;
  logic [OW-1:0] owner_q;
  logic [OW-1:0] ptr_q;
  logic [N-1:0]  gnt_q;
  logic          busy_q;

  shared_reg_if #(.W(W)) u_R ();

  logic          own_req;
  logic          own_lock;
  logic          commit;
  logic [OW-1:0] ptr_nxt;
  logic [OW-1:0] pick_ptr;
  logic [N-1:0]  pick_excl;
  logic          pick_found;
  logic [OW-1:0] pick_idx;
  logic [N-1:0]  pick_oh;
  logic [W-1:0]  wmask_sel;
  logic [W-1:0]  wdata_sel;
  logic [W-1:0]  x_d;

  // gnt_q is the one-hot of owner_q while granted and zero when idle,
  // so it doubles as the owner select everywhere below.
  assign own_req  = |(i_req & gnt_q);
  assign own_lock = |(i_lock & gnt_q);
  assign commit   = (state_q == GRANT) && own_req;
  assign ptr_nxt  = (owner_q == OW'(N - 1)) ? '0 : owner_q + OW'(1);

  // When leaving an owner the search starts past it and skips it for this pick.
  assign pick_ptr  = (state_q == GRANT) ? ptr_nxt : ptr_q;
  assign pick_excl = (state_q == GRANT) ? gnt_q : '0;

  rr_pick #(
    .N  (N),
    .OW (OW)
  ) u_pick (
    .req_i   (i_req),
    .ptr_i   (pick_ptr),
    .excl_i  (pick_excl),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // One-hot of the picked requester for the registered grant.
  always_comb begin
    pick_oh           = '0;
    pick_oh[pick_idx] = 1'b1;
  end

  // AND-OR select of the owner's mask and data lanes.
  always_comb begin
    wmask_sel = '0;
    wdata_sel = '0;
    for (int k = 0; k < N; k++) begin
      wmask_sel = wmask_sel | (i_wmask[k*W +: W] & {W{gnt_q[k]}});
      wdata_sel = wdata_sel | (i_wdata[k*W +: W] & {W{gnt_q[k]}});
    end
  end

  assign x_d = commit ? ((wdata_sel & wmask_sel) | (u_R.x & ~wmask_sel)) : u_R.x;

  // Arbitration FSM with registered grant, owner and busy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q <= GRANT;
            owner_q <= pick_idx;
            gnt_q   <= pick_oh;
            busy_q  <= 1'b1;
          end
        end
        GRANT: begin
          if (!(own_lock && own_req)) begin
            ptr_q <= ptr_nxt;
            if (pick_found) begin
              owner_q <= pick_idx;
              gnt_q   <= pick_oh;
            end else begin
              state_q <= IDLE;
              owner_q <= '0;
              gnt_q   <= '0;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Each register bit has its own flop process so consumers can treat bits independently.
  for (genvar b = 0; b < W; b++) begin : g_bit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        u_R.x[b] <= 1'b0;
      end else begin
        u_R.x[b] <= x_d[b];
      end
    end
  end

  assign o_gnt   = gnt_q;
  assign o_owner = owner_q;
  assign o_busy  = busy_q;
  assign o_q     = u_R.x;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed scoreboard bench for shared_reg_arbiter (N=4, W=8).
module tb_shared_reg_arbiter;
  import shared_reg_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N-1:0]   lock;
  logic [N*W-1:0] wmask;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   o_gnt;
  logic [1:0]     o_owner;
  logic           o_busy;
  logic [W-1:0]   o_q;

  typedef struct packed {
    logic [N-1:0] gnt;
    owner_t       owner;
  } gexp_t;

  gexp_t        gq[$];
  logic [W-1:0] qq[$];
  gexp_t        mon_e;
  logic [W-1:0] prev_q;
  bit           mon_en = 1'b0;
  int           n_checks = 0;
  int           n_pass = 0;

  shared_reg_arbiter #(.N(N), .W(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_req   (req),
    .i_lock  (lock),
    .i_wmask (wmask),
    .i_wdata (wdata),
    .o_gnt   (o_gnt),
    .o_owner (o_owner),
    .o_busy  (o_busy),
    .o_q     (o_q)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_lane(int k, logic [W-1:0] m, logic [W-1:0] d);
    wmask[k*W +: W] = m;
    wdata[k*W +: W] = d;
  endtask

  task automatic exp_g(logic [N-1:0] g, owner_t o);
    gexp_t t;
    t.gnt   = g;
    t.owner = o;
    gq.push_back(t);
  endtask

  task automatic exp_q(logic [W-1:0] v);
    qq.push_back(v);
  endtask

  // Monitor: every granted sample pops one grant expectation; every change of o_q pops one value.
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_busy || (o_gnt != '0)) begin
        if (gq.size() == 0) begin
          check("unexpected_grant", 32'({o_busy, o_gnt}), 32'(0));
        end else begin
          mon_e = gq.pop_front();
          check("gnt", 32'(o_gnt), 32'(mon_e.gnt));
          check("owner", 32'(o_owner), 32'(mon_e.owner));
          check("busy", 32'(o_busy), 32'(1));
        end
      end
      if (o_q !== prev_q) begin
        if (qq.size() == 0) check("unexpected_q_change", 32'(o_q), 32'(prev_q));
        else check("q", 32'(o_q), 32'(qq.pop_front()));
      end
    end
    prev_q = o_q;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    wmask = '0;
    wdata = '0;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      req   = 4'($urandom);
      lock  = 4'($urandom);
      wmask = $urandom;
      wdata = $urandom;
      @(negedge clk);
      check("rst_q", 32'(o_q), 32'h00);
      check("rst_gnt", 32'(o_gnt), 32'h0);
      check("rst_busy", 32'(o_busy), 32'h0);
      check("rst_owner", 32'(o_owner), 32'h0);
    end
    @(posedge clk);
    #1;
    req   = '0;
    lock  = '0;
    wmask = '0;
    wdata = '0;
    #2;
    rst_n = 1'b1;
    cyc(1);
    mon_en = 1'b1;

    // Single write from requester 0: q 00 -> 05, ptr -> 1
    set_lane(0, 8'h0F, 8'hA5);
    exp_g(4'b0001, 2'd0);
    exp_q(8'h05);
    req = 4'b0001;
    cyc(2);
    req = '0;
    cyc(2);

    // Lock burst by 1 (3 writes) with 2 pending, then 2 with no gap; ptr -> 3
    set_lane(1, 8'hF0, 8'h10);
    set_lane(2, 8'h0F, 8'h0C);
    exp_g(4'b0010, 2'd1);
    exp_g(4'b0010, 2'd1);
    exp_g(4'b0010, 2'd1);
    exp_g(4'b0100, 2'd2);
    exp_q(8'h15);
    exp_q(8'h25);
    exp_q(8'h35);
    exp_q(8'h3C);
    req  = 4'b0110;
    lock = 4'b0010;
    cyc(2);
    set_lane(1, 8'hF0, 8'h20);
    cyc(1);
    set_lane(1, 8'hF0, 8'h30);
    lock = '0;
    cyc(1);
    req = 4'b0100;
    cyc(1);
    req = '0;
    cyc(2);

    // Wrap-around from ptr=3: 3 first (q -> BC), then 0 with mask 0; ptr -> 1
    set_lane(3, 8'h80, 8'h80);
    set_lane(0, 8'h00, 8'hFF);
    exp_g(4'b1000, 2'd3);
    exp_g(4'b0001, 2'd0);
    exp_q(8'hBC);
    req = 4'b1001;
    cyc(2);
    req = 4'b0001;
    cyc(1);
    req = '0;
    cyc(2);

    // Grantee 3 withdraws before writing: no write, release, ptr -> 0
    set_lane(3, 8'hFF, 8'h00);
    exp_g(4'b1000, 2'd3);
    req = 4'b1000;
    cyc(1);
    req = '0;
    cyc(1);
    @(negedge clk);
    check("withdraw_q", 32'(o_q), 32'hBC);
    check("withdraw_busy", 32'(o_busy), 32'h0);
    cyc(1);

    // All four request from ptr=0: grants 0,1,2,3 back to back
    set_lane(0, 8'h01, 8'h01);
    set_lane(1, 8'h02, 8'h02);
    set_lane(2, 8'h80, 8'h00);
    set_lane(3, 8'h0C, 8'h00);
    exp_g(4'b0001, 2'd0);
    exp_g(4'b0010, 2'd1);
    exp_g(4'b0100, 2'd2);
    exp_g(4'b1000, 2'd3);
    exp_q(8'hBD);
    exp_q(8'hBF);
    exp_q(8'h3F);
    exp_q(8'h33);
    req = 4'b1111;
    cyc(1);
    for (int k = 0; k < N; k++) begin
      cyc(1);
      req[k] = 1'b0;
    end
    cyc(2);

    // Locked burst by 0, then async reset mid-burst
    set_lane(0, 8'hFF, 8'hAA);
    exp_g(4'b0001, 2'd0);
    exp_g(4'b0001, 2'd0);
    exp_q(8'hAA);
    req  = 4'b0001;
    lock = 4'b0001;
    cyc(2);
    #5;
    mon_en = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_gnt", 32'(o_gnt), 32'h0);
    check("midrst_busy", 32'(o_busy), 32'h0);
    check("midrst_owner", 32'(o_owner), 32'h0);
    check("midrst_q", 32'(o_q), 32'h00);
    cyc(2);
    check("midrst_hold_gnt", 32'(o_gnt), 32'h0);
    check("midrst_hold_q", 32'(o_q), 32'h00);
    req  = '0;
    lock = '0;
    #2;
    rst_n = 1'b1;
    cyc(2);
    mon_en = 1'b1;
    cyc(3);

    check("grant_queue_empty", 32'(gq.size()), 32'(0));
    check("q_queue_empty", 32'(qq.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
